pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
Parametrised inter-stage pipeline register for the 5-stage core; the generalised successor of the fixed-field MEM/WB buffer.
- Carries an opaque payload plus a vector of write-enable bits and a valid flag.
- Honours the shared 6-bit stall vector: load when this stage runs, inject a bubble when the upstream stage stalls but the downstream stage runs, hold when both stall.
- Adds a synchronous flush, a consecutive-hold counter for hazard debug, and optional performance counters.

Parameters:
DW, 64, payload width in bits (data, hi, lo, register address packed by the instantiating stage).
NWE, 2, number of write-enable bits (e.g. bit0 GPR write, bit1 HILO write).
STALL_W, 6, width of the global stall vector.
STAGE, 4, index of this buffer's upstream-stage bit in stall; stall[STAGE+1] is the downstream bit; legal range 0..STALL_W-2.
NOP_DATA, 0, payload value loaded on reset, flush or bubble.
HCW, 8, width of the hold counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
stall  in  STALL_W  global pipeline stall vector, bit i high = stage i paused.
flush  in  1  synchronous flush (exception/branch kill).
in_valid  in  1  upstream slot holds a real instruction.
in_wen  in  NWE  upstream write enables.
in_data  in  DW  upstream payload.
out_valid  out  1  registered valid.
out_wen  out  NWE  registered write enables.
out_data  out  DW  registered payload.
hold_cnt  out  HCW  consecutive cycles spent in HOLD, saturating.
bubble_cnt  out  32  bubbles injected (PIPE_STAGE_PERF_EN only, else constant 0).
hold_total  out  32  total hold cycles (PIPE_STAGE_PERF_EN only, else constant 0).

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. On reset: out_valid=0, out_wen=0, out_data=NOP_DATA, hold_cnt=0, bubble_cnt=0, hold_total=0.
- Per-edge action is chosen by strict priority:
  1. rst: reset values as above.
  2. flush: same values as reset except the perf counters, which are kept. Flush overrides any stall combination.
  3. LOAD (stall[STAGE]=0): out_* <= in_*; hold_cnt <= 0. The value of stall[STAGE+1] is ignored in this case.
  4. BUBBLE (stall[STAGE]=1, stall[STAGE+1]=0): out_valid=0, out_wen=0, out_data=NOP_DATA; hold_cnt <= 0; bubble_cnt++.
  5. HOLD (stall[STAGE]=1, stall[STAGE+1]=1): out_* unchanged; hold_cnt++ saturating at 2^HCW-1; hold_total++.
- Latency: 1 cycle from in_* to out_* in LOAD.
- Write enables are also gated by validity: out_wen is captured as in_wen AND {NWE{in_valid}}. An invalid slot therefore never asserts a write.
- Payload is opaque. No field decoding and no width conversion.
- Counters: bubble_cnt and hold_total saturate at 0xFFFFFFFF and do not wrap.
- Stall pattern (0,1) on (stall[STAGE], stall[STAGE+1]) is treated as LOAD. The stall controller never generates it, but the behaviour is still defined.
- Mid-operation reset or flush while in HOLD: clears hold_cnt on that same edge.

Optional Feature:
PIPE_STAGE_PERF_EN
- Defined: bubble_cnt and hold_total are 32-bit saturating registers behaving as specified above.
- Undefined: no counter flops are synthesised; both ports are driven constant 0.
- hold_cnt is always present, regardless of the macro.

Test Plan:
1. Reset: rst=1 for 2 cycles, with in_data=0xDEAD_BEEF, in_wen=2'b11 and in_valid=1 driven throughout -> out_valid=0, out_wen=0, out_data=0, hold_cnt=0.
2. LOAD: stall=6'b000000, in_valid=1, in_wen=2'b01, in_data=0x0000_0000_1234_5678 -> next edge out_wen=2'b01, out_data=0x1234_5678. Same inputs with in_valid=0 -> out_wen=2'b00.
3. BUBBLE: after a load of 0xAA, stall=6'b011111 for 1 cycle -> out_valid=0, out_wen=0, out_data=0, bubble_cnt=1 (with PIPE_STAGE_PERF_EN).
4. HOLD with saturation: after a load of 0x55, stall=6'b111111 for 300 cycles -> out_data stays 0x55 throughout, hold_cnt=255, hold_total=300. Then stall=0 -> hold_cnt=0 on the next edge.
5. Flush priority: in HOLD with stall=6'b111111, pulse flush=1 -> out_valid=0, out_data=0, hold_cnt=0, while hold_total keeps its accumulated value.
6. Parameter sweep: STAGE=2, DW=8, NWE=1, stall=6'b000100 -> bubble injected; stall=6'b001100 -> hold. Rebuild without PIPE_STAGE_PERF_EN -> bubble_cnt=hold_total=0 in all cases.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//
// Parametrised inter-stage pipeline register for the 5-stage core. Carries an
// opaque payload, a vector of write-enable bits and a valid flag from the
// upstream stage to the downstream stage, under control of the shared stall
// vector.
//
// Per-edge action, highest priority first:
//   rst    : everything cleared, including the performance counters
//   flush  : slot cleared and hold_cnt cleared, performance counters kept
//   LOAD   : stall[STAGE] = 0 (stall[STAGE+1] is ignored)
//   BUBBLE : stall[STAGE] = 1, stall[STAGE+1] = 0 -> NOP slot, bubble_cnt++
//   HOLD   : stall[STAGE] = 1, stall[STAGE+1] = 1 -> slot kept, hold_cnt++
//
// Stall protocol: there is no valid/ready handshake. A high stall bit means
// that stage is paused this cycle. stall[STAGE] gates whether this buffer
// accepts the upstream slot. stall[STAGE+1] tells whether the downstream
// stage consumes the current slot. A slot is consumed on every edge where the
// downstream stage runs.
//
// Configuration macro:
//   PIPE_STAGE_PERF_EN - when defined, bubble_cnt and hold_total are 32-bit
//                        saturating counters. When undefined, no counter
//                        flops exist and both ports read constant 0.
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous reset, active-high
//   stall      in   STALL_W  global stall vector, bit i high = stage i paused
//   flush      in   1        synchronous flush (exception / branch kill)
//   in_valid   in   1        upstream slot holds a real instruction
//   in_wen     in   NWE      upstream write enables
//   in_data    in   DW       upstream payload
//   out_valid  out  1        registered valid
//   out_wen    out  NWE      registered write enables (gated by in_valid)
//   out_data   out  DW       registered payload
//   hold_cnt   out  HCW      consecutive HOLD cycles, saturating
//   bubble_cnt out  32       bubbles injected (perf build only)
//   hold_total out  32       total HOLD cycles (perf build only)
//
// STAGE must lie in 0..STALL_W-2 so that stall[STAGE+1] exists.
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
  parameter int              DW       = 64,
  parameter int              NWE      = 2,
  parameter int              STALL_W  = 6,
  parameter int              STAGE    = 4,
  parameter logic [DW-1:0]   NOP_DATA = '0,
  parameter int              HCW      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [NWE-1:0]     in_wen,
  input  logic [DW-1:0]      in_data,
  output logic               out_valid,
  output logic [NWE-1:0]     out_wen,
  output logic [DW-1:0]      out_data,
  output logic [HCW-1:0]     hold_cnt,
  output logic [31:0]        bubble_cnt,
  output logic [31:0]        hold_total
);

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2
  } act_e;

  act_e act;

  // Only two bits of the shared stall vector matter to this buffer. The rest
  // are folded here so that they are visibly consumed.
  logic unused_stall;
  assign unused_stall = ^stall;

  // Stall decode. The pattern (0,1) is never produced by the stall
  // controller. It falls into LOAD because the upstream stage is running.
  always_comb begin
    act = ACT_LOAD;
    if (stall[STAGE]) begin
      act = stall[STAGE+1] ? ACT_HOLD : ACT_BUBBLE;
    end
  end

  // -------------------------------------------------------------------------
  // Slot registers and consecutive-hold counter
  // -------------------------------------------------------------------------
  logic           valid_q, valid_d;
  logic [NWE-1:0] wen_q,   wen_d;
  logic [DW-1:0]  data_q,  data_d;
  logic [HCW-1:0] hcnt_q,  hcnt_d;

  always_comb begin
    valid_d = valid_q;
    wen_d   = wen_q;
    data_d  = data_q;
    hcnt_d  = hcnt_q;
    if (rst || flush) begin
      valid_d = 1'b0;
      wen_d   = '0;
      data_d  = NOP_DATA;
      hcnt_d  = '0;
    end else begin
      case (act)
        ACT_LOAD: begin
          valid_d = in_valid;
          // An invalid slot must never request a register-file write.
          wen_d   = in_wen & {NWE{in_valid}};
          data_d  = in_data;
          hcnt_d  = '0;
        end
        ACT_BUBBLE: begin
          valid_d = 1'b0;
          wen_d   = '0;
          data_d  = NOP_DATA;
          hcnt_d  = '0;
        end
        default: begin
          if (hcnt_q != {HCW{1'b1}}) begin
            hcnt_d = hcnt_q + HCW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    wen_q   <= wen_d;
    data_q  <= data_d;
    hcnt_q  <= hcnt_d;
  end

  assign out_valid = valid_q;
  assign out_wen   = wen_q;
  assign out_data  = data_q;
  assign hold_cnt  = hcnt_q;

  // -------------------------------------------------------------------------
  // Optional performance counters. A flush does not clear these; only reset
  // clears them. Both counters stick at all-ones instead of wrapping.
  // -------------------------------------------------------------------------
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] bub_q, bub_d;
  logic [31:0] htot_q, htot_d;

  always_comb begin
    bub_d  = bub_q;
    htot_d = htot_q;
    if (rst) begin
      bub_d  = '0;
      htot_d = '0;
    end else if (!flush) begin
      if (act == ACT_BUBBLE && bub_q != 32'hFFFF_FFFF) begin
        bub_d = bub_q + 32'd1;
      end
      if (act == ACT_HOLD && htot_q != 32'hFFFF_FFFF) begin
        htot_d = htot_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    bub_q  <= bub_d;
    htot_q <= htot_d;
  end

  assign bubble_cnt = bub_q;
  assign hold_total = htot_q;
`else
  assign bubble_cnt = 32'd0;
  assign hold_total = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Two instances: dut uses the default parameters (STAGE=4, DW=64, NWE=2), and
// dut2 uses STAGE=2, DW=8, NWE=1. The driver tasks apply one cycle of inputs
// at the falling edge. Each task pushes the hand-computed register contents
// expected after the next rising edge. The monitor pops one entry 1 ns after
// every rising edge and compares the flagged instance.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;

`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;

  // dut (defaults)
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_wen = '0;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic [1:0]  out_wen;
  logic [63:0] out_data;
  logic [7:0]  hold_cnt;
  logic [31:0] bubble_cnt, hold_total;

  // dut2 (STAGE=2, DW=8, NWE=1)
  logic [5:0]  stall2 = '0;
  logic        flush2 = 1'b0;
  logic        in_valid2 = 1'b0;
  logic [0:0]  in_wen2 = '0;
  logic [7:0]  in_data2 = '0;
  logic        out_valid2;
  logic [0:0]  out_wen2;
  logic [7:0]  out_data2;
  logic [7:0]  hold_cnt2;
  logic [31:0] bubble_cnt2, hold_total2;

  pipe_stage_buf dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wen(in_wen), .in_data(in_data),
    .out_valid(out_valid), .out_wen(out_wen), .out_data(out_data),
    .hold_cnt(hold_cnt), .bubble_cnt(bubble_cnt), .hold_total(hold_total)
  );

  pipe_stage_buf #(.DW(8), .NWE(1), .STAGE(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall2), .flush(flush2),
    .in_valid(in_valid2), .in_wen(in_wen2), .in_data(in_data2),
    .out_valid(out_valid2), .out_wen(out_wen2), .out_data(out_data2),
    .hold_cnt(hold_cnt2), .bubble_cnt(bubble_cnt2), .hold_total(hold_total2)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        chk1;
    logic        chk2;
    logic        v;
    logic [1:0]  wen;
    logic [63:0] data;
    logic [7:0]  hc;
    logic [31:0] bub;
    logic [31:0] ht;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  int checks = 0;
  int errors = 0;

  // Model of the perf counters for each instance (0 when the feature is off).
  int unsigned bub_m = 0, ht_m = 0, bub2_m = 0, ht2_m = 0;

  task automatic check(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0h expected=%0h at %0t", nm, fld, act, exp, $time);
    end
  endtask

  exp_t  mon_e;
  string mon_nm;

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      if (mon_e.chk1) begin
        check(mon_nm, "out_valid",  64'(out_valid),  64'(mon_e.v));
        check(mon_nm, "out_wen",    64'(out_wen),    64'(mon_e.wen));
        check(mon_nm, "out_data",   out_data,        mon_e.data);
        check(mon_nm, "hold_cnt",   64'(hold_cnt),   64'(mon_e.hc));
        check(mon_nm, "bubble_cnt", 64'(bubble_cnt), 64'(mon_e.bub));
        check(mon_nm, "hold_total", 64'(hold_total), 64'(mon_e.ht));
      end
      if (mon_e.chk2) begin
        check(mon_nm, "out_valid2",  64'(out_valid2),  64'(mon_e.v));
        check(mon_nm, "out_wen2",    64'(out_wen2),    64'(mon_e.wen));
        check(mon_nm, "out_data2",   64'(out_data2),   mon_e.data);
        check(mon_nm, "hold_cnt2",   64'(hold_cnt2),   64'(mon_e.hc));
        check(mon_nm, "bubble_cnt2", 64'(bubble_cnt2), 64'(mon_e.bub));
        check(mon_nm, "hold_total2", 64'(hold_total2), 64'(mon_e.ht));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc1(input string nm, input logic r, input logic f, input logic [5:0] st,
                      input logic iv, input logic [1:0] iw, input logic [63:0] id,
                      input logic ev, input logic [1:0] ew, input logic [63:0] ed,
                      input logic [7:0] eh);
    exp_t e;
    @(negedge clk);
    rst = r; flush = f; stall = st; in_valid = iv; in_wen = iw; in_data = id;
    e = '0;
    e.chk1 = 1'b1;
    e.v = ev; e.wen = ew; e.data = ed; e.hc = eh;
    e.bub = PERF ? bub_m : 32'd0;
    e.ht  = PERF ? ht_m  : 32'd0;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic cyc2(input string nm, input logic f, input logic [5:0] st,
                      input logic iv, input logic iw, input logic [7:0] id,
                      input logic ev, input logic ew, input logic [7:0] ed,
                      input logic [7:0] eh);
    exp_t e;
    @(negedge clk);
    rst = 1'b0; flush2 = f; stall2 = st; in_valid2 = iv; in_wen2 = iw; in_data2 = id;
    e = '0;
    e.chk2 = 1'b1;
    e.v = ev; e.wen = {1'b0, ew}; e.data = {56'd0, ed}; e.hc = eh;
    e.bub = PERF ? bub2_m : 32'd0;
    e.ht  = PERF ? ht2_m  : 32'd0;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held for two edges with live inputs present.
    cyc1("reset0", 1, 0, 6'b000000, 1, 2'b11, 64'hDEAD_BEEF, 0, 2'b00, 64'h0, 8'd0);
    cyc1("reset1", 1, 0, 6'b000000, 1, 2'b11, 64'hDEAD_BEEF, 0, 2'b00, 64'h0, 8'd0);

    // LOAD, valid and invalid slots.
    cyc1("load_v",   0, 0, 6'b000000, 1, 2'b01, 64'h1234_5678, 1, 2'b01, 64'h1234_5678, 8'd0);
    cyc1("load_inv", 0, 0, 6'b000000, 0, 2'b01, 64'h1234_5678, 0, 2'b00, 64'h1234_5678, 8'd0);

    // BUBBLE after a load of 0xAA.
    cyc1("load_aa", 0, 0, 6'b000000, 1, 2'b11, 64'hAA, 1, 2'b11, 64'hAA, 8'd0);
    bub_m++;
    cyc1("bubble",  0, 0, 6'b011111, 1, 2'b11, 64'hBB, 0, 2'b00, 64'h0, 8'd0);

    // HOLD for 300 cycles; hold_cnt saturates at 255, the input changes are ignored.
    cyc1("load_55", 0, 0, 6'b000000, 1, 2'b10, 64'h55, 1, 2'b10, 64'h55, 8'd0);
    for (int i = 1; i <= 300; i++) begin
      ht_m++;
      cyc1("hold_sat", 0, 0, 6'b111111, 1, 2'b01, 64'h99, 1, 2'b10, 64'h55,
           (i > 255) ? 8'd255 : 8'(i));
    end
    cyc1("release", 0, 0, 6'b000000, 1, 2'b01, 64'h66, 1, 2'b01, 64'h66, 8'd0);

    // Pattern (0,1) loads.
    cyc1("stall_01", 0, 0, 6'b100000, 1, 2'b11, 64'h77, 1, 2'b11, 64'h77, 8'd0);

    // Flush in the middle of a HOLD: slot and hold_cnt clear, perf kept.
    for (int i = 1; i <= 3; i++) begin
      ht_m++;
      cyc1("hold3", 0, 0, 6'b111111, 0, 2'b00, 64'h0, 1, 2'b11, 64'h77, 8'(i));
    end
    cyc1("flush_hold", 0, 1, 6'b111111, 1, 2'b11, 64'hCC, 0, 2'b00, 64'h0, 8'd0);
    ht_m++;
    cyc1("hold_after_flush", 0, 0, 6'b111111, 1, 2'b11, 64'hCC, 0, 2'b00, 64'h0, 8'd1);

    // Flush also overrides a LOAD.
    cyc1("load_dd",    0, 0, 6'b000000, 1, 2'b11, 64'hDD, 1, 2'b11, 64'hDD, 8'd0);
    cyc1("flush_load", 0, 1, 6'b000000, 1, 2'b11, 64'hEE, 0, 2'b00, 64'h0, 8'd0);

    // Reset in the middle of a HOLD clears everything, including perf.
    cyc1("load_f0", 0, 0, 6'b000000, 1, 2'b01, 64'hF0, 1, 2'b01, 64'hF0, 8'd0);
    ht_m++;
    cyc1("hold_pre_rst", 0, 0, 6'b111111, 1, 2'b01, 64'h1, 1, 2'b01, 64'hF0, 8'd1);
    bub_m = 0; ht_m = 0;
    cyc1("rst_hold", 1, 0, 6'b111111, 1, 2'b01, 64'h1, 0, 2'b00, 64'h0, 8'd0);

    // Second instance: STAGE=2 decodes stall[2] / stall[3].
    cyc2("p_load",   0, 6'b000000, 1, 1'b1, 8'h3C, 1, 1'b1, 8'h3C, 8'd0);
    bub2_m++;
    cyc2("p_bubble", 0, 6'b000100, 1, 1'b1, 8'h11, 0, 1'b0, 8'h00, 8'd0);
    cyc2("p_load5a", 0, 6'b000000, 1, 1'b1, 8'h5A, 1, 1'b1, 8'h5A, 8'd0);
    ht2_m++;
    cyc2("p_hold1",  0, 6'b001100, 1, 1'b1, 8'h22, 1, 1'b1, 8'h5A, 8'd1);
    ht2_m++;
    cyc2("p_hold2",  0, 6'b001100, 0, 1'b0, 8'h22, 1, 1'b1, 8'h5A, 8'd2);
    cyc2("p_upper",  0, 6'b110000, 0, 1'b1, 8'h33, 0, 1'b0, 8'h33, 8'd0);
    bub2_m++;
    cyc2("p_bubble2",0, 6'b000100, 1, 1'b1, 8'h44, 0, 1'b0, 8'h00, 8'd0);
    cyc2("p_flush",  1, 6'b001100, 1, 1'b1, 8'h55, 0, 1'b0, 8'h00, 8'd0);

    // Drain the scoreboard, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
